simd_accumulate: RTL and testbench
==================================

# simd_accumulate

Lane-split accumulator directly downstream of the SIMD multiplier. It consumes a stream of 16-bit product vectors and sums them per lane over a group of beats, for dot products. Lane carries are broken according to the H/O/Q mode, with optional per-lane saturation. Results are emitted through a valid/ready handshake to the writeback stage.

## Interface
- `MAX_LEN`, default 16: maximum beats per group; the counter forces group termination at this count.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: product beat valid.
- `in_ready` out 1: beat accepted when `in_valid & in_ready` at a rising edge.
- `in_data` in 16: product vector (multiplier output).
- `in_h`, `in_o`, `in_q` in 1 each: lane mode.
  - Priority is H > O > Q; all low is treated as Q.
  - H = one 16-bit lane; O = two 8-bit lanes; Q = four 4-bit lanes.
- `in_last` in 1: marks the final beat of a group.
- `sat_en` in 1: saturate (1) or wrap (0); sampled with the first beat.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumed on `out_valid & out_ready`.
- `out_data` out 16: per-lane sums.
- `out_ovf` out 4: sticky per-lane overflow. Bit i maps to lane i; unused bits are 0 (H uses bit 0; O uses bits 1:0).
- `out_len_err` out 1: group was cut at `MAX_LEN` without `in_last`.
- `busy` out 1: high whenever state is not IDLE.

## Operation
States and transitions:
- IDLE: `in_ready`=1. An accepted beat does all of the following and moves to ACC, or to DONE if `in_last` is set:
  - latches mode and `sat_en`;
  - loads `acc` = `in_data`;
  - clears `ovf`;
  - sets `cnt`=1.
- ACC: `in_ready`=1. Each accepted beat does `acc` = lane_add(`acc`, `in_data`), ORs new lane overflows into `ovf`, and increments `cnt`.
  - Moves to DONE when `in_last` is set, or when the incremented `cnt` equals `MAX_LEN`.
  - The `MAX_LEN` case without `in_last` sets `len_err`.
- DONE: `in_ready`=0 and `out_valid`=1. On `out_ready`, go to IDLE; `acc`, `ovf`, `cnt` and `len_err` clear.

Lane arithmetic:
- Unsigned.
- The carry out of each lane's MSB is killed; it never propagates into the next lane.
- A lane overflows when its carry out is 1.
- Wrap mode: the lane keeps the low bits.
- Saturate mode: the lane is forced to all-ones (0xF, 0xFF or 0xFFFF).

Other rules:
- Mode and `sat_en` are held from the first beat. Changes on later beats of the same group are ignored.
- `out_data`, `out_ovf` and `out_len_err` are driven from registers. They are stable for the whole time `out_valid` is high.

## Timing
- Reset values:
  - state IDLE;
  - `in_ready`=1;
  - `out_valid`=0;
  - `out_data`=0x0000;
  - `out_ovf`=0;
  - `out_len_err`=0;
  - `busy`=0.
- Throughput is one beat per cycle while in IDLE or ACC.
- Latency: if the last beat is accepted at edge k, `out_valid` is 1 from edge k through the output handshake edge.
- Single-beat group (first beat has `in_last`): IDLE → DONE directly, and `out_data` equals `in_data`.
- After the output handshake at edge m, `in_ready` is 1 from edge m. There is no bypass, so a group costs N beats plus at least 1 DONE cycle.
- `out_ready` is ignored outside DONE. `in_valid` is ignored while `in_ready`=0.
- Asserting `rst_n` low mid-group immediately discards the partial sum and returns all outputs to their reset values.

## Structure
- Package `simd_pkg` holds:
  - the mode enum {MODE_Q, MODE_O, MODE_H} and a function decoding H/O/Q with H > O > Q priority;
  - lane-boundary masks 0x000F/0x00FF/0xFFFF per lane position, shared with the multiplier;
  - the `SAT` constants.
- Sub-module `simd_lane_adder` is purely combinational:
  - inputs `a`, `b` (16 bits), mode, `sat_en`;
  - outputs sum (16 bits) and `lane_ovf` (4 bits);
  - built as four 4-bit adder slices with carry gating controlled by mode.
- The top level holds the FSM, the counter and the registers.

## Test plan
1. Q, wrap: beats 0x1234, then 0x1111 with last → `out_data`=0x2345, `ovf`=0000, `len_err`=0.
2. Q, carry kill: 0x000F, then 0x0001 with last. Wrap → 0x0000 with `ovf`=0001. Sat → 0x000F with `ovf`=0001. In both cases lane 1 stays 0.
3. O: 0x80FF, then 0x8001 with last. Wrap → 0x0000 with `ovf`=0011. Sat → 0xFFFF with `ovf`=0011. H with the same stimulus, wrap → 0x0100 with `ovf`=0001.
4. Backpressure: `out_ready` held low for 5 cycles. `in_ready`=0 and `out_data` is held throughout. A beat presented meanwhile is accepted only in the cycle after the output handshake.
5. `MAX_LEN`=16: 16 beats of 0x0001 in H mode, no last → `out_data`=0x0010 and `out_len_err`=1. The 17th beat starts a new group.
6. Reset mid-group after 3 beats → outputs take reset values. A following single-beat group of 0xABCD with last → 0xABCD.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD datapath: lane modes, lane masks, saturation
// values and the accumulator FSM encoding.
package simd_pkg;

  typedef enum logic [1:0] {MODE_Q, MODE_O, MODE_H} mode_t;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  localparam logic [3:0]  SAT_Q = 4'hF;
  localparam logic [7:0]  SAT_O = 8'hFF;
  localparam logic [15:0] SAT_H = 16'hFFFF;

  localparam logic [15:0] LANE_MASK_Q = {12'h000, SAT_Q};
  localparam logic [15:0] LANE_MASK_O = {8'h00, SAT_O};
  localparam logic [15:0] LANE_MASK_H = SAT_H;

  // H wins over O, O over Q; no bit set falls back to quad lanes.
  function automatic mode_t decode_mode(input logic h, input logic o, input logic q);
    casez ({h, o, q})
      3'b1??:  return MODE_H;
      3'b01?:  return MODE_O;
      default: return MODE_Q;
    endcase
  endfunction

  function automatic logic [15:0] lane_mask(input mode_t mode);
    case (mode)
      MODE_H:  return LANE_MASK_H;
      MODE_O:  return LANE_MASK_O;
      default: return LANE_MASK_Q;
    endcase
  endfunction

  function automatic int lane_width(input mode_t mode);
    case (mode)
      MODE_H:  return 16;
      MODE_O:  return 8;
      default: return 4;
    endcase
  endfunction

endpackage

// File: rtl/simd_lane_adder.sv
// Combinational lane-split adder: four 4-bit slices whose inter-slice carries
// are gated by the lane mode, with optional per-lane saturation.
module simd_lane_adder
  import simd_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  mode_t       mode,
  input  logic        sat_en,
  output logic [15:0] sum,
  output logic [3:0]  lane_ovf
);

  logic [3:0]  link;
  logic [3:0]  cout;
  logic [15:0] raw;
  logic [15:0] sat_fill;

  // link[i] lets slice i-1's carry into slice i; lane boundaries break it
  always_comb begin
    case (mode)
      MODE_H:  link = 4'b1110;
      MODE_O:  link = 4'b1010;
      default: link = 4'b0000;
    endcase
  end

  always_comb begin
    logic c;
    raw  = '0;
    cout = '0;
    c    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {cout[i], raw[i*4 +: 4]} = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0, c & link[i]};
      c = cout[i];
    end
  end

  always_comb begin
    case (mode)
      MODE_H:  lane_ovf = {3'b000, cout[3]};
      MODE_O:  lane_ovf = {2'b00, cout[3], cout[1]};
      default: lane_ovf = cout;
    endcase
  end

  always_comb begin
    sat_fill = '0;
    for (int l = 0; l < 4; l++)
      if (lane_ovf[l]) sat_fill = sat_fill | (lane_mask(mode) << (l * lane_width(mode)));
    sum = sat_en ? (raw | sat_fill) : raw;
  end

endmodule

// File: rtl/simd_accumulate.sv
// Per-lane accumulator over a group of product beats, with a valid/ready
// result port toward writeback.
//
// state  | meaning
// S_IDLE | waiting for the first beat of a group
// S_ACC  | summing further beats into acc
// S_DONE | result held on out_*, waiting for out_ready
module simd_accumulate
  import simd_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_h,
  input  logic        in_o,
  input  logic        in_q,
  input  logic        in_last,
  input  logic        sat_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [3:0]  out_ovf,
  output logic        out_len_err,
  output logic        busy
);

  localparam int CW = $clog2(MAX_LEN + 1);

  state_t         state, state_nxt;
  mode_t          mode_r;
  logic           sat_r;
  logic [15:0]    acc;
  logic [3:0]     ovf;
  logic           len_err;
  logic [CW-1:0]  cnt_rem;
  logic [15:0]    sum;
  logic [3:0]     lane_ovf;
  logic           cnt_tc;

  simd_lane_adder u_adder (
    .a        (acc),
    .b        (in_data),
    .mode     (mode_r),
    .sat_en   (sat_r),
    .sum      (sum),
    .lane_ovf (lane_ovf)
  );

  assign out_data    = acc;
  assign out_ovf     = ovf;
  assign out_len_err = len_err;
  // beats remaining before the group is forced closed
  assign cnt_tc      = (cnt_rem <= CW'(1));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? S_DONE : S_ACC;
      end
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid && (in_last || cnt_tc)) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mode_r  <= MODE_Q;
      sat_r   <= 1'b0;
      acc     <= '0;
      ovf     <= '0;
      len_err <= 1'b0;
      cnt_rem <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (in_valid) begin
          mode_r  <= decode_mode(in_h, in_o, in_q);
          sat_r   <= sat_en;
          acc     <= in_data;
          ovf     <= '0;
          len_err <= 1'b0;
          cnt_rem <= CW'(MAX_LEN - 1);
        end
        S_ACC: if (in_valid) begin
          acc     <= sum;
          ovf     <= ovf | lane_ovf;
          cnt_rem <= cnt_rem - CW'(1);
          if (!in_last && cnt_tc) len_err <= 1'b1;
        end
        S_DONE: if (out_ready) begin
          acc     <= '0;
          ovf     <= '0;
          len_err <= 1'b0;
          cnt_rem <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_accumulate.sv
// Bench for simd_accumulate: directed vectors, hand-written corner sequences
// and a random stream compared against a per-lane arithmetic model.
module tb_simd_accumulate;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_data;
  logic        in_h, in_o, in_q, in_last, sat_en;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_ovf;
  logic        out_len_err, busy;

  always #5 clk = ~clk;

  simd_accumulate #(.MAX_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_h(in_h), .in_o(in_o), .in_q(in_q),
    .in_last(in_last), .sat_en(sat_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .out_len_err(out_len_err), .busy(busy)
  );

  int checks = 0;
  int passes = 0;

  // reference model state
  int          m_cnt = 0;
  int          m_w   = 4;
  bit          m_sat = 0;
  logic [15:0] m_acc = '0;
  logic [3:0]  m_ovf = '0;
  logic [15:0] e_data;
  logic [3:0]  e_ovf;
  bit          e_len;

  typedef struct {
    bit h, o, q, sat;
    logic [15:0] b0, b1, exp_d;
    logic [3:0]  exp_o;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_add(input logic [15:0] a, input logic [15:0] b, input int w,
                                    input bit sat, output logic [15:0] s, output logic [3:0] ov);
    int mask;
    mask = (1 << w) - 1;
    s  = '0;
    ov = '0;
    for (int l = 0; l < 16 / w; l++) begin
      int x, y, t;
      x = (int'(a) >> (l * w)) & mask;
      y = (int'(b) >> (l * w)) & mask;
      t = x + y;
      if (t > mask) begin
        ov[l] = 1'b1;
        t = sat ? mask : (t & mask);
      end
      s = s | 16'(t << (l * w));
    end
  endfunction

  task automatic send(input logic [15:0] d, input bit h, input bit o, input bit q,
                      input bit last, input bit sat, output bit done);
    int waited;
    logic [15:0] s;
    logic [3:0]  ov;
    in_data = d; in_h = h; in_o = o; in_q = q; in_last = last; sat_en = sat;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    done = 1'b0;
    if (m_cnt == 0) begin
      m_w   = h ? 16 : (o ? 8 : 4);
      m_sat = sat;
      m_acc = d;
      m_ovf = '0;
      m_cnt = 1;
      e_len = 1'b0;
      done  = last;
    end else begin
      model_add(m_acc, d, m_w, m_sat, s, ov);
      m_acc = s;
      m_ovf = m_ovf | ov;
      m_cnt++;
      if (last) done = 1'b1;
      else if (m_cnt == 16) begin
        done  = 1'b1;
        e_len = 1'b1;
      end
    end
    if (done) begin
      e_data = m_acc;
      e_ovf  = m_ovf;
      m_cnt  = 0;
    end
    @(negedge clk);
  endtask

  task automatic drain(input logic [15:0] exp_d, input logic [3:0] exp_o, input bit exp_len,
                       input int stall);
    int waited;
    check("latency_out_valid", 32'(out_valid), 32'd1);
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("out_data", 32'(out_data), 32'(exp_d));
    check("out_ovf", 32'(out_ovf), 32'(exp_o));
    check("out_len_err", 32'(out_len_err), 32'(exp_len));
    check("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_data", 32'(out_data), 32'(exp_d));
      check("hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("post_hs_valid", 32'(out_valid), 32'd0);
    check("post_hs_ready", 32'(in_ready), 32'd1);
    check("post_hs_data", 32'(out_data), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    rst_n = 1'b0; in_valid = 0; in_data = '0; in_h = 0; in_o = 0; in_q = 0;
    in_last = 0; sat_en = 0; out_ready = 0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_len_err", 32'(out_len_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    tbl[0] = '{0, 0, 1, 0, 16'h1234, 16'h1111, 16'h2345, 4'h0};
    tbl[1] = '{0, 0, 1, 0, 16'h000F, 16'h0001, 16'h0000, 4'h1};
    tbl[2] = '{0, 0, 1, 1, 16'h000F, 16'h0001, 16'h000F, 4'h1};
    tbl[3] = '{0, 1, 0, 0, 16'h80FF, 16'h8001, 16'h0000, 4'h3};
    tbl[4] = '{0, 1, 0, 1, 16'h80FF, 16'h8001, 16'hFFFF, 4'h3};
    tbl[5] = '{1, 0, 0, 0, 16'h80FF, 16'h8001, 16'h0100, 4'h1};
    tbl[6] = '{0, 0, 0, 0, 16'h000F, 16'h0001, 16'h0000, 4'h1};
    tbl[7] = '{1, 1, 0, 0, 16'h80FF, 16'h8001, 16'h0100, 4'h1};
    tbl[8] = '{0, 0, 1, 1, 16'h8F37, 16'h9F1A, 16'hFF4F, 4'hD};
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].b0, tbl[i].h, tbl[i].o, tbl[i].q, 1'b0, tbl[i].sat, done);
      check("busy_acc", 32'(busy), 32'd1);
      // later-beat mode/sat bits are random: they must not matter
      send(tbl[i].b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'($urandom), done);
      drain(tbl[i].exp_d, tbl[i].exp_o, 1'b0, i % 3);
    end

    // backpressure: a beat waiting during DONE is taken only after the handshake
    send(16'h0102, 0, 1, 0, 1'b0, 1'b0, done);
    send(16'h0304, 0, 1, 0, 1'b1, 1'b0, done);
    in_data = 16'h7777; in_h = 1; in_o = 0; in_q = 0; in_last = 1; sat_en = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_data", 32'(out_data), 32'h0406);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_after_hs_valid", 32'(out_valid), 32'd0);
    check("bp_after_hs_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_new_valid", 32'(out_valid), 32'd1);
    check("bp_new_data", 32'(out_data), 32'h7777);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);

    // MAX_LEN cut: 16 beats without last
    for (int i = 0; i < 16; i++) send(16'h0001, 1, 0, 0, 1'b0, 1'b0, done);
    check("maxlen_done", 32'(done), 32'd1);
    drain(16'h0010, 4'h0, 1'b1, 1);
    send(16'h0005, 1, 0, 0, 1'b1, 1'b0, done);
    drain(16'h0005, 4'h0, 1'b0, 0);

    // reset mid-group
    for (int i = 0; i < 3; i++) send(16'h1111, 0, 0, 1, 1'b0, 1'b0, done);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_acc", 32'(out_data), 32'h3333);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'hABCD, 1, 0, 0, 1'b1, 1'b0, done);
    drain(16'hABCD, 4'h0, 1'b0, 0);

    // random stream against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      out_ready = 1'($urandom);
      send(16'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 5) == 0), 1'($urandom), done);
      if (done) drain(e_data, e_ovf, e_len, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
